// File: rtl/gpio_pkg.sv
// Shared types and defaults for the GPIO switch input conditioning path.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package gpio_pkg;

    typedef enum logic {
        DB_STABLE   = 1'b0,
        DB_SETTLING = 1'b1
    } debounce_state_e;

    localparam int unsigned DefaultDebounceCycles = 50000;
    localparam int unsigned DefaultSyncStages     = 2;

endpackage

// File: rtl/gpio_debounce_bit.sv
// One-bit synchroniser + debouncer producing a clean level and rise/fall pulses.
// Latency: SyncStages + DebounceCycles cycles from a clean pin step to sw_o.
// Backpressure: none; free-running, one sample per clock.
module gpio_debounce_bit
    import gpio_pkg::*;
#(
    parameter int unsigned SyncStages     = DefaultSyncStages,
    parameter int unsigned DebounceCycles = DefaultDebounceCycles
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned     CntW    = $clog2(DebounceCycles + 1);
    localparam logic [CntW-1:0] CntLast = CntW'(DebounceCycles - 1);

    logic [SyncStages-1:0] sync_q;
    logic                  s;
    debounce_state_e       state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic                  sw_q, sw_d;
    logic                  rise_q, rise_d;
    logic                  fall_q, fall_d;

    // Plain flop chain: nothing may sit between metastability stages.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SyncStages-2:0], sw_i};
        end
    end

    assign s = sync_q[SyncStages-1];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sw_d    = sw_q;
        unique case (state_q)
            DB_STABLE: begin
                cnt_d = '0;
                if (s != sw_q) begin
                    // A one-sample debounce window needs no settling phase.
                    if (DebounceCycles == 1) begin
                        sw_d = s;
                    end else begin
                        state_d = DB_SETTLING;
                        cnt_d   = CntW'(1);
                    end
                end
            end
            DB_SETTLING: begin
                if (s == sw_q) begin
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else if (cnt_q == CntLast) begin
                    sw_d    = s;
                    state_d = DB_STABLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = DB_STABLE;
                cnt_d   = '0;
            end
        endcase
        rise_d = sw_d & ~sw_q;
        fall_d = ~sw_d & sw_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= DB_STABLE;
            cnt_q   <= '0;
            sw_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sw_q    <= sw_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_o   = sw_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;

endmodule

// File: rtl/gpio_input_conditioner.sv
// Per-bit sync/debounce of raw switch pins; GPIO_IRQ_EN adds sticky edge status + irq.
// Latency: SyncStages + DebounceCycles to sw_o; edge_status +1, irq_o +2 after a pulse.
// Backpressure: none; free-running.
module gpio_input_conditioner
    import gpio_pkg::*;
#(
    parameter int unsigned NumInputs      = 4,
    parameter int unsigned SyncStages     = DefaultSyncStages,
    parameter int unsigned DebounceCycles = DefaultDebounceCycles
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [NumInputs-1:0] sw_i,
`ifdef GPIO_IRQ_EN
    input  logic [NumInputs-1:0] irq_enable_i,
    input  logic [NumInputs-1:0] irq_clear_i,
    output logic [NumInputs-1:0] edge_status_o,
    output logic                 irq_o,
`endif
    output logic [NumInputs-1:0] sw_o,
    output logic [NumInputs-1:0] rise_o,
    output logic [NumInputs-1:0] fall_o
);

    for (genvar i = 0; i < NumInputs; i++) begin : g_bit
        gpio_debounce_bit #(
            .SyncStages    (SyncStages),
            .DebounceCycles(DebounceCycles)
        ) u_debounce_bit (
            .clk_i (clk_i),
            .rst_ni(rst_ni),
            .sw_i  (sw_i[i]),
            .sw_o  (sw_o[i]),
            .rise_o(rise_o[i]),
            .fall_o(fall_o[i])
        );
    end

`ifdef GPIO_IRQ_EN
    logic [NumInputs-1:0] status_q;
    logic                 irq_q;

    // Set has priority so an edge coinciding with a clear is never lost.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            status_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            status_q <= (status_q & ~irq_clear_i) | rise_o | fall_o;
            irq_q    <= |(status_q & irq_enable_i);
        end
    end

    assign edge_status_o = status_q;
    assign irq_o         = irq_q;
`endif

endmodule

// File: tb/tb_gpio_input_conditioner.sv
// Randomised + directed bench for gpio_input_conditioner against a sample-window model.
module tb_gpio_input_conditioner;

    localparam int NI = 4;
    localparam int SS = 2;
    localparam int DC = 8;
    localparam int HistDepth = DC + SS;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [NI-1:0] sw_i;
    logic [NI-1:0] sw_o, rise_o, fall_o;
`ifdef GPIO_IRQ_EN
    logic [NI-1:0] irq_enable_i, irq_clear_i, edge_status_o;
    logic          irq_o;
`endif

    gpio_input_conditioner #(
        .NumInputs     (NI),
        .SyncStages    (SS),
        .DebounceCycles(DC)
    ) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .sw_i         (sw_i),
`ifdef GPIO_IRQ_EN
        .irq_enable_i (irq_enable_i),
        .irq_clear_i  (irq_clear_i),
        .edge_status_o(edge_status_o),
        .irq_o        (irq_o),
`endif
        .sw_o         (sw_o),
        .rise_o       (rise_o),
        .fall_o       (fall_o)
    );

    always #5 clk_i = ~clk_i;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;
    int rise_cnt [NI];
    int fall_cnt [NI];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: hist[k] is the pin sampled k edges ago. sw_o flips at an edge when the
    // DC samples the debouncer sees (pin delayed by SS edges) all differ from it.
    logic [NI-1:0] hist [HistDepth];
    logic [NI-1:0] m_sw, m_rise, m_fall, m_status;
    logic          m_irq;

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int k = 0; k < HistDepth; k++) hist[k] = '0;
            m_sw = '0; m_rise = '0; m_fall = '0; m_status = '0; m_irq = 1'b0;
        end else begin
            logic [NI-1:0] nsw;
`ifdef GPIO_IRQ_EN
            m_irq    = |(m_status & irq_enable_i);
            m_status = (m_status & ~irq_clear_i) | m_rise | m_fall;
`endif
            for (int k = HistDepth - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = sw_i;
            nsw = m_sw;
            for (int b = 0; b < NI; b++) begin
                bit all_diff;
                all_diff = 1'b1;
                for (int j = 0; j < DC; j++)
                    if (hist[SS + j][b] == m_sw[b]) all_diff = 1'b0;
                if (all_diff) nsw[b] = ~m_sw[b];
            end
            m_rise = nsw & ~m_sw;
            m_fall = ~nsw & m_sw;
            m_sw   = nsw;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            chk("cyc_sw_o", sw_o, m_sw);
            chk("cyc_rise_o", rise_o, m_rise);
            chk("cyc_fall_o", fall_o, m_fall);
`ifdef GPIO_IRQ_EN
            chk("cyc_edge_status", edge_status_o, m_status);
            chk("cyc_irq", irq_o, m_irq);
`endif
        end
        for (int b = 0; b < NI; b++) begin
            if (rise_o[b] === 1'b1) rise_cnt[b]++;
            if (fall_o[b] === 1'b1) fall_cnt[b]++;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #2;
    endtask

    initial begin
        int r1, f1, r2, cut;
        rst_ni = 1'b0;
        sw_i   = '0;
`ifdef GPIO_IRQ_EN
        irq_enable_i = '0;
        irq_clear_i  = '0;
`endif
        tick(3);
        rst_ni = 1'b1;
        cmp_en = 1'b1;

        tick(20);
        chk("idle_sw", sw_o, 4'b0000);
        chk("idle_pulses", {rise_o, fall_o}, 8'h00);
`ifdef GPIO_IRQ_EN
        chk("idle_irq", irq_o, 1'b0);
`endif

        sw_i[0] = 1'b1;
        tick(9);
        chk("step_b0_early", sw_o[0], 1'b0);
        tick(1);
        chk("step_b0_sw", sw_o, 4'b0001);
        chk("step_b0_rise", rise_o, 4'b0001);
        chk("model_step_sw", m_sw, 4'b0001);
        tick(1);
        chk("step_b0_rise_end", rise_o, 4'b0000);

        r1 = rise_cnt[1];
        f1 = fall_cnt[1];
        sw_i[1] = 1'b1;
        tick(5);
        sw_i[1] = 1'b0;
        tick(15);
        chk("glitch_b1_sw", sw_o[1], 1'b0);
        chk("glitch_b1_pulses", (rise_cnt[1] - r1) + (fall_cnt[1] - f1), 0);

        r2 = rise_cnt[2];
        for (int i = 0; i < 5; i++) begin
            sw_i[2] = (i % 2 == 0);
            if (i < 4) tick(3);
        end
        tick(9);
        chk("bounce_b2_early", sw_o[2], 1'b0);
        tick(1);
        chk("bounce_b2_rise", rise_o, 4'b0100);
        tick(5);
        chk("bounce_b2_count", rise_cnt[2] - r2, 1);
        chk("bounce_sw", sw_o, 4'b0101);
        chk("model_bounce_sw", m_sw, 4'b0101);

        sw_i[3] = 1'b1;
        tick(7);
        rst_ni = 1'b0;
        tick(2);
        chk("rst_sw", sw_o, 4'b0000);
        chk("model_rst_sw", m_sw, 4'b0000);
        rst_ni = 1'b1;
        chk("rst_release_sw", sw_o, 4'b0000);
        tick(9);
        chk("rst_b3_early", sw_o[3], 1'b0);
        tick(1);
        chk("rst_b3_sw", sw_o, 4'b1101);
        chk("rst_b3_rise", rise_o, 4'b1101);

`ifdef GPIO_IRQ_EN
        sw_i[0] = 1'b0;
        tick(12);
        irq_enable_i = 4'b0001;
        irq_clear_i  = 4'hF;
        tick(1);
        irq_clear_i  = '0;
        tick(2);
        chk("irq_cleared", irq_o, 1'b0);
        sw_i[0] = 1'b1;
        tick(10);
        chk("irq_rise_b0", rise_o[0], 1'b1);
        tick(1);
        chk("irq_status_set", edge_status_o[0], 1'b1);
        tick(1);
        chk("irq_asserted", irq_o, 1'b1);
        sw_i[0] = 1'b0;
        tick(10);
        chk("irq_fall_b0", fall_o[0], 1'b1);
        irq_clear_i = 4'b0001;
        tick(1);
        chk("irq_set_wins", edge_status_o[0], 1'b1);
        tick(1);
        chk("irq_clear_alone", edge_status_o[0], 1'b0);
        irq_clear_i = '0;
        tick(1);
        chk("irq_deasserted", irq_o, 1'b0);
`endif

        for (int c = 0; c < 3000; c++) begin
            cut = (c < 1000) ? 4 : ((c < 2000) ? 12 : 30);
            if (c == 1500) rst_ni = 1'b0;
            if (c == 1503) rst_ni = 1'b1;
            for (int b = 0; b < NI; b++)
                if ($urandom_range(0, cut - 1) == 0) sw_i[b] = ~sw_i[b];
`ifdef GPIO_IRQ_EN
            irq_enable_i = NI'($urandom);
            irq_clear_i  = ($urandom_range(0, 7) == 0) ? NI'($urandom) : '0;
`endif
            tick(1);
        end
        tick(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
